// File: rtl/retire_pkg.sv
// Shared types and helpers for the in-order retirement scheduler.
package retire_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] rob_tag_t;

    typedef struct packed {
        logic valid;
        logic done;
    } rob_entry_t;

    // Advance a ring pointer by n (0..2); depth is a power of two, so the modulo is a mask.
    function automatic logic [31:0] tag_inc(input logic [31:0] tag, input logic [1:0] n,
                                            input logic [31:0] depth);
        tag_inc = (tag + {30'd0, n}) % depth;
    endfunction

endpackage

// File: rtl/retire_pair_select.sv
// Commit decision for the two oldest entries; slot 1 may only retire behind slot 0.
module retire_pair_select
    import retire_pkg::*;
(
    input  rob_entry_t i_entry0,
    input  rob_entry_t i_entry1,
    output logic       o_commit0,
    output logic       o_commit1
);

    // Head retires when complete; head+1 only rides along with it.
    always_comb begin
        o_commit0 = i_entry0.valid & i_entry0.done;
        o_commit1 = o_commit0 & i_entry1.valid & i_entry1.done;
    end

endmodule

// File: rtl/retire_scheduler.sv
// Dual-issue in-order retirement scheduler: tag allocation, completion tracking,
// and up to two in-order commits per cycle from a circular buffer.
module retire_scheduler
    import retire_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc0_i,
    input  logic             alloc1_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag0_o,
    output logic [TAG_W-1:0] alloc_tag1_o,
    input  logic             done0_i,
    input  logic [TAG_W-1:0] done0_tag_i,
    input  logic             done1_i,
    input  logic [TAG_W-1:0] done1_tag_i,
    input  logic             flush_i,
    output logic             commit0_o,
    output logic             commit1_o,
    output logic [TAG_W-1:0] commit_tag0_o,
    output logic [TAG_W-1:0] commit_tag1_o,
    output logic [TAG_W:0]   count_o
);

    rob_entry_t       r_entry [DEPTH];
    rob_entry_t       w_entry_nxt [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic [TAG_W-1:0] w_head1;
    logic [TAG_W-1:0] w_tail1;
    logic [TAG_W-1:0] w_head_nxt;
    logic [TAG_W-1:0] w_tail_nxt;
    logic [TAG_W:0]   w_count_nxt;
    logic             w_ready;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_sel0;
    logic             w_sel1;
    logic [1:0]       w_n_alloc;
    logic [1:0]       w_n_commit;

    retire_pair_select u_pair_select (
        .i_entry0  (r_entry[r_head]),
        .i_entry1  (r_entry[w_head1]),
        .o_commit0 (w_sel0),
        .o_commit1 (w_sel1)
    );

    // Space check uses registered occupancy only, so same-cycle commits never free room.
    always_comb begin
        w_head1    = TAG_W'(tag_inc(32'(r_head), 2'd1, 32'(DEPTH)));
        w_tail1    = TAG_W'(tag_inc(32'(r_tail), 2'd1, 32'(DEPTH)));
        w_ready    = (r_count <= (TAG_W+1)'(DEPTH - 2));
        w_acc0     = alloc0_i & w_ready;
        w_acc1     = alloc0_i & alloc1_i & w_ready;
        w_n_alloc  = w_acc1 ? 2'd2 : (w_acc0 ? 2'd1 : 2'd0);
        w_n_commit = w_sel1 ? 2'd2 : (w_sel0 ? 2'd1 : 2'd0);
        w_head_nxt = TAG_W'(tag_inc(32'(r_head), w_n_commit, 32'(DEPTH)));
        w_tail_nxt = TAG_W'(tag_inc(32'(r_tail), w_n_alloc, 32'(DEPTH)));
        w_count_nxt = r_count + (TAG_W+1)'(w_n_alloc) - (TAG_W+1)'(w_n_commit);
    end

    // Per-entry next state. Allocated slots are always free and committing slots always
    // valid, so set and clear never target the same entry in one cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((w_acc0 && (r_tail == TAG_W'(i))) || (w_acc1 && (w_tail1 == TAG_W'(i)))) begin
                w_entry_nxt[i].valid = 1'b1;
                w_entry_nxt[i].done  = 1'b0;
            end else if ((w_sel0 && (r_head == TAG_W'(i))) ||
                         (w_sel1 && (w_head1 == TAG_W'(i)))) begin
                w_entry_nxt[i].valid = 1'b0;
                w_entry_nxt[i].done  = 1'b0;
            end else begin
                w_entry_nxt[i].valid = r_entry[i].valid;
                w_entry_nxt[i].done  = r_entry[i].done |
                                       (r_entry[i].valid &
                                        ((done0_i & (done0_tag_i == TAG_W'(i))) |
                                         (done1_i & (done1_tag_i == TAG_W'(i)))));
            end
        end
    end

    // State registers; flush returns everything to the reset image.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_nxt[i];
            end
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Output view of registered state; commits are suppressed during a flush.
    always_comb begin
        alloc_ready_o = w_ready;
        alloc_tag0_o  = r_tail;
        alloc_tag1_o  = alloc0_i ? w_tail1 : r_tail;
        commit0_o     = w_sel0 & ~flush_i;
        commit1_o     = w_sel1 & ~flush_i;
        commit_tag0_o = r_head;
        commit_tag1_o = w_head1;
        count_o       = r_count;
    end

endmodule
